// File: rtl/contador_checker.sv
// contador_checker: reference model and comparator for the 16-bit mode counter.
// Tracks the counter's expected Q after the first observed load, flags
// mismatches on Q and the whole-counter terminal count RCO[3], and
// resynchronises to the counter's own value one cycle after a mismatch.
module contador_checker #(
    parameter int WIDTH     = 16,
    parameter bit CHECK_RCO = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q,
    input  logic [3:0]       RCO,
    output logic [WIDTH-1:0] q_exp,
    output logic             synced,
    output logic             err,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] first_err_q
);

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] UP3_WRAP = ALL_ONES - WIDTH'(2);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] adv_model;   // model advanced from its own value
    logic [WIDTH-1:0] adv_q;       // model advanced from the counter's Q
    logic [WIDTH-1:0] q_exp_nxt;
    logic             rco_exp;
    logic             mismatch;
    logic             unused_rco;

    // Only the whole-counter carry is checked; lower nibble carries are ignored.
    assign unused_rco = ^RCO[2:0];

    // Next-count function applied both to the model and to the observed Q.
    always_comb begin
        adv_model = q_exp;
        adv_q     = Q;
        if (enb) begin
            case (modo)
                2'b00: begin
                    adv_model = q_exp + WIDTH'(1);
                    adv_q     = Q + WIDTH'(1);
                end
                2'b01: begin
                    adv_model = q_exp - WIDTH'(1);
                    adv_q     = Q - WIDTH'(1);
                end
                2'b10: begin
                    adv_model = q_exp + WIDTH'(3);
                    adv_q     = Q + WIDTH'(3);
                end
                default: begin
                    adv_model = D;
                    adv_q     = D;
                end
            endcase
        end
    end

    // Expected terminal count, derived from the counter's present Q.
    always_comb begin
        rco_exp = 1'b0;
        if (enb) begin
            case (modo)
                2'b00:   rco_exp = (Q == ALL_ONES);
                2'b01:   rco_exp = (Q == '0);
                2'b10:   rco_exp = (Q >= UP3_WRAP);
                default: rco_exp = 1'b0;
            endcase
        end
    end

    // A mismatch is only meaningful while the model is tracking.
    always_comb begin
        mismatch = 1'b0;
        if (state == TRACK) begin
            mismatch = (Q != q_exp) || (CHECK_RCO && (RCO[3] != rco_exp));
        end
    end

    // Next state and next model value.
    always_comb begin
        state_nxt = state;
        q_exp_nxt = q_exp;
        case (state)
            UNSYNC: begin
                if (enb && (modo == 2'b11)) begin
                    q_exp_nxt = D;
                    state_nxt = TRACK;
                end
            end
            TRACK: begin
                q_exp_nxt = adv_model;
                if (mismatch) begin
                    state_nxt = RESYNC;
                end
            end
            RESYNC: begin
                // adv_q already yields D when a load is presented at this edge.
                q_exp_nxt = adv_q;
                state_nxt = TRACK;
            end
            default: begin
                state_nxt = UNSYNC;
            end
        endcase
    end

    // State and model registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= UNSYNC;
            q_exp <= '0;
        end else begin
            state <= state_nxt;
            q_exp <= q_exp_nxt;
        end
    end

    // Mismatch bookkeeping: saturating count and first offending Q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count   <= '0;
            first_err_q <= '0;
        end else if (mismatch) begin
            if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
            if (err_count == 16'd0) begin
                first_err_q <= Q;
            end
        end
    end

    assign synced = (state == TRACK);
    assign err    = (state == RESYNC);

endmodule

// File: tb/tb_contador_checker.sv
// Directed bench for contador_checker: the bench plays the counter (driving
// Q/RCO), keeps a behavioural model of the checker outputs, and compares on
// every falling edge, plus hand-computed literal expectations.
module tb_contador_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        enb;
    logic [1:0]  modo;
    logic [15:0] D;
    logic [15:0] Q;
    logic [3:0]  RCO;
    logic [15:0] q_exp;
    logic        synced;
    logic        err;
    logic [15:0] err_count;
    logic [15:0] first_err_q;

    int unsigned errors = 0;
    int unsigned checks = 0;
    bit          done   = 1'b0;

    // bench-side counter
    logic [15:0] cnt = 16'd0;

    // behavioural model of the checker outputs
    bit          m_sync   = 1'b0;
    bit          m_resync = 1'b0;
    logic [15:0] m_q      = 16'd0;
    logic [15:0] m_cnt    = 16'd0;
    logic [15:0] m_first  = 16'd0;

    contador_checker #(.WIDTH(16), .CHECK_RCO(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .enb        (enb),
        .modo       (modo),
        .D          (D),
        .Q          (Q),
        .RCO        (RCO),
        .q_exp      (q_exp),
        .synced     (synced),
        .err        (err),
        .err_count  (err_count),
        .first_err_q(first_err_q)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] nxt(input logic [15:0] v, input logic e,
                                        input logic [1:0] m, input logic [15:0] d);
        int x;
        if (!e) return v;
        case (m)
            2'b00:   x = int'(v) + 1;
            2'b01:   x = int'(v) + 65535;
            2'b10:   x = int'(v) + 3;
            default: x = int'(d);
        endcase
        return 16'(x % 65536);
    endfunction

    function automatic logic rco_fn(input logic [15:0] v, input logic e, input logic [1:0] m);
        if (!e) return 1'b0;
        if (m == 2'b00) return v == 16'hFFFF;
        if (m == 2'b01) return v == 16'h0000;
        if (m == 2'b10) return int'(v) >= 65533;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync = 1'b0; m_resync = 1'b0; m_q = '0; m_cnt = '0; m_first = '0;
    endtask

    // One clock of stimulus; Q/RCO come from the bench counter, RCO[3] optionally corrupted.
    task automatic step(input logic e, input logic [1:0] m, input logic [15:0] d,
                        input logic rflip);
        logic [15:0] qd;
        logic        rd;
        @(negedge clk);
        enb = e; modo = m; D = d;
        qd = cnt;
        rd = rco_fn(cnt, e, m) ^ rflip;
        Q = qd;
        RCO = {rd, 3'b000};
        @(posedge clk);
        if (m_resync) begin
            m_q = nxt(qd, e, m, d);
            m_resync = 1'b0;
            m_sync = 1'b1;
        end else if (m_sync) begin
            bit mis;
            mis = (qd != m_q) || (rd != rco_fn(qd, e, m));
            m_q = nxt(m_q, e, m, d);
            if (mis) begin
                if (m_cnt == 16'd0) m_first = qd;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                m_sync = 1'b0;
                m_resync = 1'b1;
            end
        end else if (e && m == 2'b11) begin
            m_q = d;
            m_sync = 1'b1;
        end
        cnt = nxt(cnt, e, m, d);
        #1;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!done) begin
            chk("q_exp",       {16'd0, q_exp},       {16'd0, m_q});
            chk("synced",      {31'd0, synced},      {31'd0, m_sync});
            chk("err",         {31'd0, err},         {31'd0, m_resync});
            chk("err_count",   {16'd0, err_count},   {16'd0, m_cnt});
            chk("first_err_q", {16'd0, first_err_q}, {16'd0, m_first});
        end
    end

    initial begin
        reset = 1'b1; enb = 1'b0; modo = 2'b00; D = '0; Q = '0; RCO = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        // idle: enb low, including a load pattern that must be ignored
        for (int i = 0; i < 5; i++) step(1'b0, (i == 2) ? 2'b11 : 2'b00, 16'h1234, 1'b0);
        chk("idle_synced", {31'd0, synced}, 32'd0);
        chk("idle_errcnt", {16'd0, err_count}, 32'd0);

        // load 5 then count up
        step(1'b1, 2'b11, 16'h0005, 1'b0);
        chk("load5_synced", {31'd0, synced}, 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 2'b00, 16'h0000, 1'b0);
        chk("up_to_9", {16'd0, q_exp}, 32'h0009);

        // wrap upward by 3
        step(1'b1, 2'b11, 16'hFFFE, 1'b0);
        step(1'b1, 2'b10, 16'h0000, 1'b0);
        chk("fffe_plus3", {16'd0, q_exp}, 32'h0001);

        // wrap downward
        step(1'b1, 2'b11, 16'h0000, 1'b0);
        step(1'b1, 2'b01, 16'h0000, 1'b0);
        chk("zero_minus1", {16'd0, q_exp}, 32'hFFFF);
        chk("no_err_yet", {16'd0, err_count}, 32'd0);

        // wrong Q: model 0x0010, counter jumps to 0x0013
        step(1'b1, 2'b11, 16'h000D, 1'b0);
        step(1'b1, 2'b10, 16'h0000, 1'b0);
        cnt = 16'h0013;
        step(1'b1, 2'b00, 16'h0000, 1'b0);
        chk("err_pulse", {31'd0, err}, 32'd1);
        chk("err_cnt_1", {16'd0, err_count}, 32'd1);
        chk("first_13", {16'd0, first_err_q}, 32'h0013);
        step(1'b1, 2'b00, 16'h0000, 1'b0);
        chk("resync_q", {16'd0, q_exp}, 32'h0015);
        chk("err_low", {31'd0, err}, 32'd0);
        chk("resynced", {31'd0, synced}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 16'h0000, 1'b0);
        chk("still_1_err", {16'd0, err_count}, 32'd1);

        // RCO[3] corrupted at the terminal count
        step(1'b1, 2'b11, 16'hFFFF, 1'b0);
        step(1'b1, 2'b00, 16'h0000, 1'b1);
        chk("rco_err_cnt", {16'd0, err_count}, 32'd2);
        chk("first_kept", {16'd0, first_err_q}, 32'h0013);
        step(1'b1, 2'b01, 16'h0000, 1'b0);
        step(1'b1, 2'b01, 16'h0000, 1'b0);
        chk("after_rco_q", {16'd0, q_exp}, 32'hFFFE);

        // asynchronous reset between edges
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("rst_q_exp", {16'd0, q_exp}, 32'd0);
        chk("rst_synced", {31'd0, synced}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_errcnt", {16'd0, err_count}, 32'd0);
        chk("rst_first", {16'd0, first_err_q}, 32'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 16'h0000, 1'b0);
        chk("post_rst_unsync", {31'd0, synced}, 32'd0);
        step(1'b1, 2'b11, 16'h0100, 1'b0);
        step(1'b1, 2'b00, 16'h0000, 1'b0);
        chk("post_rst_track", {16'd0, q_exp}, 32'h0101);

        @(negedge clk);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/contador_checker.md
# contador_checker

Self-checking monitor that sits on the output side of the 16-bit mode counter (`contador16bits`) and reads the same `enb`/`modo`/`D` stimulus the counter receives. It keeps a reference model of the count, compares it every cycle against the counter's `Q` and `RCO[3]`, and reports mismatches. It is synthesizable and is instantiated beside the counter in the testbench, after the stimulus generator.

## Interface
- `WIDTH`, default 16: count width; must match the counter.
- `CHECK_RCO`, default 1: when 1, `RCO[3]` is compared; when 0, only `Q` is compared.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `enb`, input, 1: counter enable, sampled exactly as the counter samples it.
- `modo`, input, 2: counter mode.
- `D`, input, WIDTH: counter load value.
- `Q`, input, WIDTH: counter output under check.
- `RCO`, input, 4: per-nibble carry outputs of the counter; only `RCO[3]` (whole-counter terminal count) is checked.
- `q_exp`, output, WIDTH: current model value.
- `synced`, output, 1: high while the model is valid (state TRACK).
- `err`, output, 1: one-cycle pulse per detected mismatch.
- `err_count`, output, 16: mismatch count, saturating at 16'hFFFF.
- `first_err_q`, output, WIDTH: `Q` value captured at the first mismatch since reset.

## Operation
- Mode encoding, applied only when `enb`=1:
  - 00: up by 1.
  - 01: down by 1.
  - 10: up by 3.
  - 11: load `D`.
- With `enb`=0 the model holds.
- All arithmetic is modulo 2^WIDTH (FFFE +3 gives 0001; 0000 −1 gives FFFF).
- Expected `RCO[3]` is combinational from the current `Q`, `enb` and `modo`. It is 1 when `enb`=1 and any of:
  - `modo`=00 and `Q`=FFFF;
  - `modo`=10 and `Q`≥FFFD;
  - `modo`=01 and `Q`=0000.
- It is 0 otherwise, including in mode 11.
- States:
  - **UNSYNC (reset state):** no comparison. On an edge with `enb`=1 and `modo`=11: `q_exp`←`D`, go to TRACK. All other inputs: stay.
  - **TRACK:** on every edge compare the sampled `Q` with `q_exp`, and if CHECK_RCO=1 compare `RCO[3]` with the expected value. The model then advances from the inputs sampled at the same edge.
  - **RESYNC:** entered from TRACK on a mismatch. In this cycle `err` is high. At the next edge, `q_exp` is loaded with the function of the sampled `Q` (the counter's own value), and the state returns to TRACK. A load (`enb`=1, `modo`=11) seen at that edge takes priority and loads `D`.
- On a mismatch: `err_count`+1 (saturating). If `err_count` was 0, `first_err_q`←`Q`.
- A load during TRACK is compared like any other cycle; there is no special case.
- Reset values: state UNSYNC, `q_exp`=0, `synced`=0, `err`=0, `err_count`=0, `first_err_q`=0.

## Timing
- The counter updates `Q` on edge k from the inputs at k. The model updates on the same edge, so in TRACK `Q` and `q_exp` are equal throughout every cycle.
- Mismatch at edge k produces `err`=1 during cycle k→k+1. `err_count` and `first_err_q` are updated at edge k.
- `synced` goes high in the cycle after the first load edge. It is low during RESYNC.
- Back-to-back mismatches: RESYNC lasts one cycle, so the minimum spacing of `err` pulses is 2 cycles.
- `reset` asserted at any time forces all outputs to their reset values immediately, without waiting for a clock. After release the block waits in UNSYNC for a load.

## Test plan
- Reset, then hold `enb`=0 for 5 cycles. Required: `synced`=0, `err` never high, `err_count`=0.
- Load 0x0005 (`modo`=11), then `modo`=00 for 4 cycles. Required: `q_exp` runs 5,6,7,8,9 in step with `Q`, and `err` stays 0.
- Load 0xFFFE, then up by 3. Required: `q_exp`=0x0001, and `RCO[3]` is expected high in the FFFE cycle.
- Load 0x0000, then `modo`=01. Required: FFFF; `RCO[3]` is expected high during the 0000 cycle; no error.
- Force a wrong counter `Q` (model 0x0010, `Q`=0x0013). Required:
  - `err` pulses for 1 cycle;
  - `err_count`=1 and `first_err_q`=0x0013;
  - the model resyncs, and no further errors occur while the counter counts correctly.
- Assert `reset` mid-TRACK, between clock edges. Required: all outputs go to 0 immediately. After release the block stays in UNSYNC until the next load.
